// File: rtl/hdmi_data_island_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_data_island_decoder
// Description : Receive-side HDMI data-island packet decoder. Reassembles
//               32-cycle packets from TERC4-decoded nibbles, checks BCH
//               parity, and extracts sync, ACR (N/CTS) and L-PCM samples.
//               Optional infoframe outputs: define HDMI_DEC_INFOFRAME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_data_island_decoder #(
  parameter int CHECK_ECC = 1,
  parameter int ERR_W     = 8
) (
  input  logic             i_pixclk,
  input  logic             i_rst,
  input  logic             i_data,
  input  logic [3:0]       i_d0,
  input  logic [3:0]       i_d1,
  input  logic [3:0]       i_d2,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_hdr_valid,
  output logic [23:0]      o_hdr,
  output logic             o_acr_valid,
  output logic [19:0]      o_cts,
  output logic [19:0]      o_n,
  output logic             o_aud_valid,
  output logic [15:0]      o_aud_l,
  output logic [15:0]      o_aud_r,
`ifdef HDMI_DEC_INFOFRAME_EN
  output logic             o_if_valid,
  output logic [7:0]       o_if_type,
  output logic [55:0]      o_if_payload,
  output logic             o_if_sum_ok,
`endif
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int         SUM_W      = ERR_W + 1;
  localparam logic [7:0] c_hb0Acr   = 8'h01;
  localparam logic [7:0] c_hb0Audio = 8'h02;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_t;

  state_t            r_state, w_stateNext;
  logic [4:0]        r_cnt, w_cntNext;
  logic              w_capture, w_complete, w_frameErr;
  logic [31:0]       r_hdr, w_hdrFull;
  logic [3:0][63:0]  r_sp, w_spFull;
  logic              w_hdrOk, w_accept;
  logic [3:0]        w_spOk, w_audMask, w_pend, w_pendRest, r_qMask;
  logic [3:0][15:0]  r_qL, r_qR, w_srcL, w_srcR;
  logic [1:0]        w_pickIdx;
  logic [2:0]        w_errInc;
  logic [SUM_W-1:0]  w_errSum;

  // BCH(64,56)/(32,24) parity, returned in received order (bit i = code[7-i])
  function automatic logic [7:0] eccOf(input logic [55:0] data, input int nBits);
    logic [7:0] code;
    logic [7:0] rev;
    logic       fb;
    code = 8'h00;
    for (int i = 0; i < 56; i++) begin
      if (i < nBits) begin
        fb   = code[7] ^ data[i];
        code = {code[6:0], 1'b0} ^ (fb ? 8'hC1 : 8'h00);
      end
    end
    for (int i = 0; i < 8; i++) rev[i] = code[7-i];
    return rev;
  endfunction

  // Packet framing FSM: next state, bit counter and framing events
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_frameErr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_data) begin
          if (!i_d0[3]) begin
            w_capture   = 1'b1;
            w_cntNext   = 5'd1;
            w_stateNext = ST_RECV;
          end else begin
            w_frameErr = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (i_data) begin
          // a cleared i_d0[3] at cnt=0 starts a new island; capture is identical
          w_capture  = 1'b1;
          w_cntNext  = r_cnt + 5'd1;
          w_complete = (r_cnt == 5'd31);
        end else begin
          w_stateNext = ST_IDLE;
          w_cntNext   = 5'd0;
          w_frameErr  = (r_cnt != 5'd0);
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // FSM state and bit counter
  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Full packet view including the nibble being captured this cycle
  always_comb begin
    w_hdrFull = {i_d0[2], r_hdr[31:1]};
    for (int k = 0; k < 4; k++) begin
      w_spFull[k] = {i_d2[k], i_d1[k], r_sp[k][63:2]};
      w_spOk[k]   = (CHECK_ECC == 0) || (eccOf(w_spFull[k][55:0], 56) == w_spFull[k][63:56]);
    end
    w_hdrOk  = (CHECK_ECC == 0) || (eccOf({32'd0, w_hdrFull[23:0]}, 24) == w_hdrFull[31:24]);
    w_accept = w_complete & w_hdrOk;
  end

  // Error increment and audio sample selection for this cycle
  always_comb begin
    w_errInc = {2'b00, w_frameErr} + {2'b00, w_complete & ~w_hdrOk};
    for (int k = 0; k < 4; k++) begin
      if (w_accept && !w_spOk[k]) w_errInc = w_errInc + 3'd1;
      w_audMask[k] = w_accept && (w_hdrFull[7:0] == c_hb0Audio) && w_hdrFull[8+k] && w_spOk[k];
      w_srcL[k]    = w_complete ? w_spFull[k][23:8]  : r_qL[k];
      w_srcR[k]    = w_complete ? w_spFull[k][47:32] : r_qR[k];
    end
    // The queue is always empty when a packet completes, so no merge is needed
    w_pend    = w_complete ? w_audMask : r_qMask;
    w_pickIdx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_pend[k]) w_pickIdx = 2'(k);
    end
    w_pendRest = w_pend & ~(4'b0001 << w_pickIdx);
    w_errSum   = {1'b0, o_err_cnt} + SUM_W'(w_errInc);
  end

`ifdef HDMI_DEC_INFOFRAME_EN
  logic [27:0][7:0] w_ifBytes;
  logic [7:0]       w_ifSum;

  // Infoframe checksum over header and PB0..PB[length]
  always_comb begin
    w_ifBytes = {w_spFull[3][55:0], w_spFull[2][55:0], w_spFull[1][55:0], w_spFull[0][55:0]};
    w_ifSum   = w_hdrFull[7:0] + w_hdrFull[15:8] + w_hdrFull[23:16];
    for (int i = 0; i < 28; i++) begin
      if (i <= int'(w_hdrFull[20:16])) w_ifSum = w_ifSum + w_ifBytes[i];
    end
  end
`endif

  // Packet capture, decoded outputs, sample queue and error counter
  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      r_hdr       <= '0;
      r_sp        <= '0;
      r_qMask     <= '0;
      r_qL        <= '0;
      r_qR        <= '0;
      o_hsync     <= 1'b0;
      o_vsync     <= 1'b0;
      o_hdr_valid <= 1'b0;
      o_hdr       <= '0;
      o_acr_valid <= 1'b0;
      o_cts       <= '0;
      o_n         <= '0;
      o_aud_valid <= 1'b0;
      o_aud_l     <= '0;
      o_aud_r     <= '0;
      o_err_cnt   <= '0;
`ifdef HDMI_DEC_INFOFRAME_EN
      o_if_valid   <= 1'b0;
      o_if_type    <= '0;
      o_if_payload <= '0;
      o_if_sum_ok  <= 1'b0;
`endif
    end else begin
      if (i_data) begin
        o_hsync <= i_d0[0];
        o_vsync <= i_d0[1];
      end
      if (w_capture) begin
        r_hdr <= w_hdrFull;
        r_sp  <= w_spFull;
      end
      o_hdr_valid <= w_accept;
      if (w_accept) o_hdr <= w_hdrFull[23:0];
      o_acr_valid <= w_accept && (w_hdrFull[7:0] == c_hb0Acr) && w_spOk[0];
      if (w_accept && (w_hdrFull[7:0] == c_hb0Acr) && w_spOk[0]) begin
        o_cts <= {w_spFull[0][11:8], w_spFull[0][23:16], w_spFull[0][31:24]};
        o_n   <= {w_spFull[0][35:32], w_spFull[0][47:40], w_spFull[0][55:48]};
      end
      o_aud_valid <= |w_pend;
      if (|w_pend) begin
        o_aud_l <= w_srcL[w_pickIdx];
        o_aud_r <= w_srcR[w_pickIdx];
      end
      r_qMask <= w_pendRest;
      if (w_complete) begin
        r_qL <= w_srcL;
        r_qR <= w_srcR;
      end
      o_err_cnt <= w_errSum[ERR_W] ? {ERR_W{1'b1}} : w_errSum[ERR_W-1:0];
`ifdef HDMI_DEC_INFOFRAME_EN
      o_if_valid <= w_accept && w_hdrFull[7];
      if (w_accept && w_hdrFull[7]) begin
        o_if_type    <= w_hdrFull[7:0];
        o_if_payload <= w_spFull[0][55:0];
        o_if_sum_ok  <= (w_ifSum == 8'h00);
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/hdmi_data_island_decoder.md
Name: hdmi_data_island_decoder

Overview:
- Receive-side companion to the HDMI data-island encoder.
- Consumes TERC4-decoded 4-bit nibbles for channels 0/1/2 during data-island periods and reassembles 32-cycle packets.
- Verifies BCH parity, then extracts sync, Audio Clock Regeneration (N/CTS) and L-PCM audio samples.
- Sits after the TMDS/TERC4 symbol decoder, ahead of the audio FIFO and the N/CTS clock-recovery logic.

Parameters:
- CHECK_ECC, 1, 1 = drop packets/subpackets whose BCH parity mismatches; 0 = ignore parity.
- ERR_W, 8, width of the saturating error counter.

Ports:
- i_pixclk  in  1  pixel clock
- i_rst  in  1  synchronous reset, active high
- i_data  in  1  high while a data-island period is being received (guard bands excluded)
- i_d0  in  4  channel 0 nibble: [0] hsync, [1] vsync, [2] header bit, [3] 0 only on cycle 0 of an island's first packet
- i_d1  in  4  channel 1 nibble: bit k = even bit of subpacket k
- i_d2  in  4  channel 2 nibble: bit k = odd bit of subpacket k
- o_hsync  out  1  registered i_d0[0], updated only while i_data
- o_vsync  out  1  registered i_d0[1], updated only while i_data
- o_hdr_valid  out  1  one-cycle pulse per accepted packet
- o_hdr  out  24  HB0..HB2 of the accepted packet (HB0 in [7:0])
- o_acr_valid  out  1  pulse; ACR packet (HB0=0x01) accepted
- o_cts  out  20  CTS from subpacket 0
- o_n  out  20  N from subpacket 0
- o_aud_valid  out  1  pulse per extracted audio sample
- o_aud_l  out  16  left sample
- o_aud_r  out  16  right sample
- o_err_cnt  out  ERR_W  saturating count of parity/framing errors

Behaviour:
- Reset: every output 0; FSM to IDLE; sample queue empty.
- FSM states:
  - IDLE: on i_data=1, i_d0[3]=0, go to RECV with bit counter cnt=0 capturing that cycle; i_d0[3]=1 in IDLE is a framing error (err+1, stay IDLE).
  - RECV: capture one nibble per cycle, cnt 0..31.
  - At cnt=31: packet complete. If i_data stays high, cnt wraps to 0 for the next packet in the same island.
  - At cnt=0 of a follow-on packet, i_d0[3] must be 1. A 0 there restarts a new island (partial/previous state discarded, no error).
  - i_data falling with cnt≠0: abort, discard the partial packet, err+1, go to IDLE.
  - i_data falling at cnt=0 (clean boundary): go to IDLE, no error.
- Bit order, LSB first:
  - Header bit n is i_d0[2] at cycle n: bits 0..23 data, 24..31 parity.
  - Subpacket k bit 2c is i_d1[k] and bit 2c+1 is i_d2[k] at cycle c: bits 0..55 data, 56..63 parity.
- BCH check:
  - code starts at 0x00; per data bit b: code = (code<<1) ^ ((code[7]^b) ? 0xC1 : 0x00).
  - Received parity bit i (i=0 first) must equal code[7-i].
  - Header mismatch (CHECK_ECC=1): whole packet dropped, err+1, no valid pulses.
  - Subpacket mismatch: that subpacket is ignored, err+1.
- Output latency: o_hdr_valid and o_acr_valid pulse on the cycle after cnt=31 is captured.
- ACR extraction: o_cts = {SB1[3:0],SB2,SB3}; o_n = {SB4[3:0],SB5,SB6}, with SBj = subpacket 0 bits [8j+7:8j].
- Audio sample packet (HB0=0x02):
  - For each k=0..3 with HB1[k]=1 and a parity-good subpacket, queue (L=sp[23:8], R=sp[47:32]).
  - Queued samples emit on consecutive cycles starting 1 cycle after completion, in ascending k; 0–4 pulses.
  - The queue always drains before the next packet can complete (≥32 cycles later), so no overflow.
- All other packet types: o_hdr_valid only.
- o_err_cnt saturates at all-ones; it does not wrap.
- o_hdr, o_cts, o_n, o_aud_l and o_aud_r hold their last values between pulses.
- Reset mid-packet or mid-drain: queue cleared, no further pulses.

Optional Feature:
- Macro HDMI_DEC_INFOFRAME_EN. When defined, adds:
  - o_if_valid (pulse), o_if_type [7:0], o_if_payload [55:0] (subpacket 0), o_if_sum_ok.
  - These fire for HB0 ≥ 0x80, same cycle as o_hdr_valid.
  - o_if_sum_ok=1 when (HB0+HB1+HB2 + all payload bytes for length HB2[4:0]) mod 256 = 0.
- When not defined: these ports are absent and infoframes produce only o_hdr_valid.

Test Plan:
- Island with ACR packet, N=6144, CTS=27000, valid BCH -> one o_acr_valid at cycle 32 after start; o_n=0x01800, o_cts=0x06978; o_err_cnt=0.
- Audio sample packet with HB1=0x3, sp0 L=0x1234/R=0xABCD, sp1 L=0x0001/R=0xFFFF -> o_aud_valid at +1 and +2 after completion with those values in order; no third pulse.
- Same as the previous audio case but sp1 parity bit 60 flipped -> only sample 0 emitted; o_err_cnt=1.
- Header parity bit flipped -> no o_hdr_valid/o_acr_valid; o_err_cnt increments; next clean packet in the same island decodes normally.
- i_data drops at cnt=17 -> no pulses, o_err_cnt+1, FSM in IDLE; a fresh island then decodes; 300 forced errors -> o_err_cnt=255.
- AVI infoframe HB=0x82,0x02,0x0D with payload 0x46,0x10,0x19 (with HDMI_DEC_INFOFRAME_EN) -> o_if_valid, o_if_type=0x82, o_if_sum_ok=1; assert i_rst mid-drain -> all outputs 0 next cycle.
